// File: rtl/rat_restore_ctrl_pkg.sv
// Shared widths, restore port count and walk FSM encoding for the RAT undo controller.
package rat_restore_ctrl_pkg;
  localparam int LOGAREG_DEF = 5;
  localparam int PREGW_DEF   = 7;
  localparam int LOGHIST_DEF = 5;
  localparam int RESTORE_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_e;
endpackage

// File: rtl/rat_hist_buf.sv
// Circular undo-record storage: 4 writes at tail+0..3, 4 combinational reads at tail-1..tail-4.
module rat_hist_buf
  import rat_restore_ctrl_pkg::*;
#(
  parameter int LOGAREG = LOGAREG_DEF,
  parameter int PREGW   = PREGW_DEF,
  parameter int LOGHIST = LOGHIST_DEF
) (
  input  logic                               clock,
  input  logic [LOGHIST-1:0]                 tail_idx,
  input  logic [RESTORE_W-1:0]               wr_en,
  input  logic [RESTORE_W-1:0][LOGAREG-1:0]  wr_areg,
  input  logic [RESTORE_W-1:0][PREGW-1:0]    wr_opreg,
  output logic [RESTORE_W-1:0][LOGAREG-1:0]  rd_areg,
  output logic [RESTORE_W-1:0][PREGW-1:0]    rd_opreg
);
  localparam int HIST = 1 << LOGHIST;
  localparam int RECW = LOGAREG + PREGW;

  logic [RECW-1:0] mem [HIST];

  always_ff @(posedge clock) begin
    for (int j = 0; j < RESTORE_W; j++) begin
      if (wr_en[j]) mem[tail_idx + LOGHIST'(j)] <= {wr_areg[j], wr_opreg[j]};
    end
  end

  always_comb begin
    rd_areg  = '0;
    rd_opreg = '0;
    for (int k = 0; k < RESTORE_W; k++) begin
      {rd_areg[k], rd_opreg[k]} = mem[tail_idx - LOGHIST'(k + 1)];
    end
  end
endmodule

// File: rtl/rat_restore_ctrl.sv
// Rename undo controller: history pointers, push compaction, misprediction walk
// that drives RAT write ports 1-4 youngest-first with duplicate suppression.
module rat_restore_ctrl
  import rat_restore_ctrl_pkg::*;
#(
  parameter int LOGAREG = LOGAREG_DEF,
  parameter int PREGW   = PREGW_DEF,
  parameter int LOGHIST = LOGHIST_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push1_valid_in,
  input  logic [LOGAREG-1:0] push1_areg_in,
  input  logic [PREGW-1:0]   push1_opreg_in,
  input  logic               push2_valid_in,
  input  logic [LOGAREG-1:0] push2_areg_in,
  input  logic [PREGW-1:0]   push2_opreg_in,
  input  logic               push3_valid_in,
  input  logic [LOGAREG-1:0] push3_areg_in,
  input  logic [PREGW-1:0]   push3_opreg_in,
  input  logic               push4_valid_in,
  input  logic [LOGAREG-1:0] push4_areg_in,
  input  logic [PREGW-1:0]   push4_opreg_in,
  input  logic [2:0]         retire_cnt_in,
  input  logic               recover_in,
  input  logic [LOGHIST:0]   recover_ptr_in,
  output logic [LOGHIST:0]   tail_ptr_out,
  output logic [LOGHIST:0]   count_out,
  output logic               full_out,
  output logic               busy_out,
  output logic               restore1_we_out,
  output logic [LOGAREG-1:0] restore1_index_out,
  output logic [PREGW-1:0]   restore1_data_out,
  output logic               restore2_we_out,
  output logic [LOGAREG-1:0] restore2_index_out,
  output logic [PREGW-1:0]   restore2_data_out,
  output logic               restore3_we_out,
  output logic [LOGAREG-1:0] restore3_index_out,
  output logic [PREGW-1:0]   restore3_data_out,
  output logic               restore4_we_out,
  output logic [LOGAREG-1:0] restore4_index_out,
  output logic [PREGW-1:0]   restore4_data_out
);
  localparam int PTRW = LOGHIST + 1;
  localparam int HIST = 1 << LOGHIST;

  walk_state_e state_q, state_d;
  logic [PTRW-1:0] head_q, tail_q, target_q;
  logic [PTRW-1:0] count, free_cnt, eff_target, remaining, dist_rec, dist_tgt;
  logic [RESTORE_W-1:0] push_valid, wr_en, live, rs_we_d, rs_we_q;
  logic [RESTORE_W-1:0][LOGAREG-1:0] push_areg, wr_areg, rd_areg, rs_index_d, rs_index_q;
  logic [RESTORE_W-1:0][PREGW-1:0] push_opreg, wr_opreg, rd_opreg, rs_data_d, rs_data_q;
  logic [2:0] n_push, batch;
  logic push_ok, issue;

  assign push_valid = {push4_valid_in, push3_valid_in, push2_valid_in, push1_valid_in};
  assign push_areg  = {push4_areg_in, push3_areg_in, push2_areg_in, push1_areg_in};
  assign push_opreg = {push4_opreg_in, push3_opreg_in, push2_opreg_in, push1_opreg_in};

  assign count    = tail_q - head_q;
  assign free_cnt = PTRW'(HIST) - count;

  rat_hist_buf #(.LOGAREG(LOGAREG), .PREGW(PREGW), .LOGHIST(LOGHIST)) u_hist (
    .clock    (clock),
    .tail_idx (tail_q[LOGHIST-1:0]),
    .wr_en    (wr_en),
    .wr_areg  (wr_areg),
    .wr_opreg (wr_opreg),
    .rd_areg  (rd_areg),
    .rd_opreg (rd_opreg)
  );

  // Pack valid slots onto consecutive write ports; an overflowing push is dropped whole.
  always_comb begin
    wr_en    = '0;
    wr_areg  = '0;
    wr_opreg = '0;
    n_push   = '0;
    for (int k = 0; k < RESTORE_W; k++) begin
      if (push_valid[k]) begin
        wr_en[n_push[1:0]]    = 1'b1;
        wr_areg[n_push[1:0]]  = push_areg[k];
        wr_opreg[n_push[1:0]] = push_opreg[k];
        n_push                = n_push + 3'd1;
      end
    end
    push_ok = (state_q == ST_IDLE) && !recover_in && (PTRW'(n_push) <= free_cnt);
    if (!push_ok) wr_en = '0;
  end

  // A nested recover only moves the target if it is older (closer to head).
  always_comb begin
    dist_rec   = recover_ptr_in - head_q;
    dist_tgt   = target_q - head_q;
    eff_target = target_q;
    if (state_q == ST_IDLE || (recover_in && dist_rec < dist_tgt)) eff_target = recover_ptr_in;
    remaining = tail_q - eff_target;
    issue     = (state_q == ST_WALK || recover_in) && (remaining != '0);
    batch     = (remaining > PTRW'(RESTORE_W)) ? 3'(RESTORE_W) : remaining[2:0];
  end

  always_comb begin
    rs_we_d    = '0;
    rs_index_d = '0;
    rs_data_d  = '0;
    live       = '0;
    for (int k = 0; k < RESTORE_W; k++) live[k] = issue && (3'(k) < batch);
    for (int k = 0; k < RESTORE_W; k++) begin
      if (live[k]) begin
        rs_index_d[k] = rd_areg[k];
        rs_data_d[k]  = rd_opreg[k];
        rs_we_d[k]    = 1'b1;
        // Only the oldest copy of an areg in the batch writes; RAT port priority is irrelevant.
        for (int j = k + 1; j < RESTORE_W; j++) begin
          if (live[j] && rd_areg[j] == rd_areg[k]) rs_we_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue)  state_d = ST_WALK;
      ST_WALK: if (!issue) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state_q == ST_WALK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      target_q <= '0;
    end else begin
      head_q <= head_q + PTRW'(retire_cnt_in);
      if (issue) begin
        tail_q   <= tail_q - PTRW'(batch);
        target_q <= eff_target;
      end else if (push_ok) begin
        tail_q <= tail_q + PTRW'(n_push);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rs_we_q    <= '0;
      rs_index_q <= '0;
      rs_data_q  <= '0;
    end else begin
      rs_we_q    <= rs_we_d;
      rs_index_q <= rs_index_d;
      rs_data_q  <= rs_data_d;
    end
  end

  assign tail_ptr_out = tail_q;
  assign count_out    = count;
  assign full_out     = count > PTRW'(HIST - RESTORE_W);

  assign restore1_we_out    = rs_we_q[0];
  assign restore2_we_out    = rs_we_q[1];
  assign restore3_we_out    = rs_we_q[2];
  assign restore4_we_out    = rs_we_q[3];
  assign restore1_index_out = rs_index_q[0];
  assign restore2_index_out = rs_index_q[1];
  assign restore3_index_out = rs_index_q[2];
  assign restore4_index_out = rs_index_q[3];
  assign restore1_data_out  = rs_data_q[0];
  assign restore2_data_out  = rs_data_q[1];
  assign restore3_data_out  = rs_data_q[2];
  assign restore4_data_out  = rs_data_q[3];
endmodule

// File: tb/tb_rat_restore_ctrl.sv
// Bench for rat_restore_ctrl: directed scenarios plus random traffic against a queue model.
module tb_rat_restore_ctrl;
  typedef struct packed {
    logic [4:0] a;
    logic [6:0] p;
  } rec_t;

  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] pv;
  logic [3:0][4:0] pa;
  logic [3:0][6:0] po;
  logic [2:0] retire;
  logic recover;
  logic [5:0] rptr;

  logic [5:0] d_tail, d_count;
  logic d_full, d_busy;
  logic [3:0] d_we;
  logic [3:0][4:0] d_idx;
  logic [3:0][6:0] d_dat;

  rec_t hist[$];
  int m_head;
  int m_target;
  bit m_walking;
  logic [3:0] e_we, e_live;
  logic [4:0] e_idx [4];
  logic [6:0] e_dat [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rat_restore_ctrl dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .push1_valid_in     (pv[0]), .push1_areg_in (pa[0]), .push1_opreg_in (po[0]),
    .push2_valid_in     (pv[1]), .push2_areg_in (pa[1]), .push2_opreg_in (po[1]),
    .push3_valid_in     (pv[2]), .push3_areg_in (pa[2]), .push3_opreg_in (po[2]),
    .push4_valid_in     (pv[3]), .push4_areg_in (pa[3]), .push4_opreg_in (po[3]),
    .retire_cnt_in      (retire),
    .recover_in         (recover),
    .recover_ptr_in     (rptr),
    .tail_ptr_out       (d_tail),
    .count_out          (d_count),
    .full_out           (d_full),
    .busy_out           (d_busy),
    .restore1_we_out    (d_we[0]), .restore1_index_out (d_idx[0]), .restore1_data_out (d_dat[0]),
    .restore2_we_out    (d_we[1]), .restore2_index_out (d_idx[1]), .restore2_data_out (d_dat[1]),
    .restore3_we_out    (d_we[2]), .restore3_index_out (d_idx[2]), .restore3_data_out (d_dat[2]),
    .restore4_we_out    (d_we[3]), .restore4_index_out (d_idx[3]), .restore4_data_out (d_dat[3])
  );

  always @(negedge clock) begin
    if (reset_n) begin
      assert (int'(retire) <= int'(d_count)) else $error("retire_cnt exceeds occupancy");
      assert (!(d_full && (pv != 4'b0))) else $error("push while full");
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    pv = '0; pa = '0; po = '0; retire = '0; recover = 1'b0; rptr = '0;
  endtask

  task automatic model_reset();
    hist.delete();
    m_head = 0; m_target = 0; m_walking = 0;
    e_we = '0; e_live = '0;
    for (int k = 0; k < 4; k++) begin e_idx[k] = '0; e_dat[k] = '0; end
  endtask

  // Reference: history is a queue from head (front) to tail (back); a walk pops from the back.
  task automatic model_step();
    int rp, rem, nb;
    rec_t b[4];
    bit was_idle;
    was_idle = !m_walking;
    e_we = '0; e_live = '0;
    for (int k = 0; k < 4; k++) begin e_idx[k] = '0; e_dat[k] = '0; end
    rp = int'(rptr);
    if (m_walking && recover) begin
      if (((rp - m_head) & 63) < ((m_target - m_head) & 63)) m_target = rp;
    end else if (recover) begin
      m_target = rp;
    end
    if (m_walking || recover) begin
      rem = (m_head + hist.size() - m_target) & 63;
      if (rem > 0) begin
        nb = (rem > 4) ? 4 : rem;
        for (int k = 0; k < nb; k++) begin
          b[k] = hist.pop_back();
          e_live[k] = 1'b1; e_idx[k] = b[k].a; e_dat[k] = b[k].p;
        end
        for (int k = 0; k < nb; k++) begin
          e_we[k] = 1'b1;
          for (int j = k + 1; j < nb; j++) if (b[j].a == b[k].a) e_we[k] = 1'b0;
        end
        m_walking = 1;
      end else begin
        m_walking = 0;
      end
    end
    if (was_idle && !recover) begin
      for (int k = 0; k < 4; k++) if (pv[k]) hist.push_back({pa[k], po[k]});
    end
    for (int i = 0; i < int'(retire); i++) if (hist.size() > 0) void'(hist.pop_front());
    m_head = (m_head + int'(retire)) & 63;
  endtask

  task automatic compare_all();
    int sz;
    sz = hist.size();
    chk("tail", 32'(d_tail), 32'((m_head + sz) & 63));
    chk("count", 32'(d_count), 32'(sz));
    chk("full", 32'(d_full), 32'(sz > 28));
    chk("busy", 32'(d_busy), 32'(m_walking));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("we%0d", k + 1), 32'(d_we[k]), 32'(e_we[k]));
      if (e_live[k]) begin
        chk($sformatf("index%0d", k + 1), 32'(d_idx[k]), 32'(e_idx[k]));
        chk($sformatf("data%0d", k + 1), 32'(d_dat[k]), 32'(e_dat[k]));
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    for (int k = 0; k < 4; k++) begin
      chk("rst_index", 32'(d_idx[k]), 32'd0);
      chk("rst_data", 32'(d_dat[k]), 32'd0);
    end
    @(posedge clock);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  task automatic push_n(input int n);
    set_idle();
    for (int k = 0; k < n; k++) begin
      pv[k] = 1'b1;
      pa[k] = 5'($urandom_range(0, 31));
      po[k] = 7'($urandom_range(0, 127));
    end
    step();
  endtask

  task automatic run_walk(inout int nbusy, inout int nwe);
    for (int i = 0; i < 20; i++) begin
      if (!m_walking) break;
      set_idle();
      step();
      nbusy += int'(d_busy);
      nwe += $countones(d_we);
    end
    chk("walk_end_busy", 32'(d_busy), 32'd0);
  endtask

  task automatic recover_to(input int ptr, inout int nbusy, inout int nwe);
    set_idle();
    recover = 1'b1;
    rptr = 6'(ptr);
    step();
    nbusy += int'(d_busy);
    nwe += $countones(d_we);
  endtask

  initial begin
    int nb, nw, sz;
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    compare_all();
    reset_n = 1'b1;

    // compaction of slots 1 and 3, then fill to the full threshold
    set_idle();
    pv = 4'b0101;
    pa[0] = 5'd2; po[0] = 7'd10; pa[1] = 5'd17; po[1] = 7'd99;
    pa[2] = 5'd5; po[2] = 7'd11; pa[3] = 5'd23; po[3] = 7'd98;
    step();
    chk("compact_count", 32'(d_count), 32'd2);
    chk("compact_tail", 32'(d_tail), 32'd2);
    while (hist.size() < 29) begin
      sz = 29 - hist.size();
      push_n(sz > 4 ? 4 : sz);
    end
    chk("full_at_29", 32'(d_full), 32'd1);
    nb = 0; nw = 0;
    recover_to(m_head, nb, nw);
    run_walk(nb, nw);

    // basic 6-record walk
    push_n(4);
    push_n(2);
    nb = 0; nw = 0;
    recover_to(m_head, nb, nw);
    run_walk(nb, nw);
    chk("basic_busy_cycles", 32'(nb), 32'd2);
    chk("basic_tail", 32'(d_tail), 32'd0);

    // reset mid-walk, then an empty recover must not raise busy
    push_n(4);
    push_n(4);
    nb = 0; nw = 0;
    recover_to(m_head, nb, nw);
    chk("midwalk_busy", 32'(d_busy), 32'd1);
    do_reset();
    recover_to(0, nb, nw);
    chk("n0_busy", 32'(d_busy), 32'd0);

    // duplicate areg 7 within one batch: only the older (preg 20) writes
    set_idle();
    pv = 4'b1111;
    pa[0] = 5'd7; po[0] = 7'd20; pa[1] = 5'd3; po[1] = 7'd1;
    pa[2] = 5'd7; po[2] = 7'd33; pa[3] = 5'd9; po[3] = 7'd2;
    step();
    nb = 0; nw = 0;
    recover_to(m_head, nb, nw);
    chk("dup_we2", 32'(d_we[1]), 32'd0);
    chk("dup_we4", 32'(d_we[3]), 32'd1);
    chk("dup_data4", 32'(d_dat[3]), 32'd20);
    run_walk(nb, nw);

    // nested recover across the index wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_idle();
      pv = 4'b0011;
      pa[0] = 5'($urandom_range(0, 31)); pa[1] = 5'($urandom_range(0, 31));
      retire = (i > 0) ? 3'd2 : 3'd0;
      step();
    end
    set_idle();
    retire = 3'd2;
    step();
    for (int g = 0; g < 2; g++) begin
      set_idle();
      pv = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        pa[k] = 5'(g * 4 + k + 1);
        po[k] = 7'($urandom_range(0, 127));
      end
      step();
    end
    nb = 0; nw = 0;
    recover_to(34, nb, nw);
    recover_to(31, nb, nw);
    run_walk(nb, nw);
    chk("nested_tail", 32'(d_tail), 32'd31);
    chk("nested_restores", 32'(nw), 32'd7);

    // recover with push and retire in the same cycle
    push_n(4);
    set_idle();
    pv = 4'b1111;
    retire = 3'd2;
    recover = 1'b1;
    rptr = 6'((m_head + 3) & 63);
    step();
    nb = 0; nw = 0;
    run_walk(nb, nw);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      sz = hist.size();
      if ((!m_walking && $urandom_range(0, 7) == 0) || (m_walking && $urandom_range(0, 3) == 0)) begin
        recover = 1'b1;
        rptr = 6'((m_head + int'($urandom_range(0, sz))) & 63);
      end
      if (sz <= 28) begin
        pv = 4'($urandom_range(0, 15));
        for (int k = 0; k < 4; k++) begin
          pa[k] = 5'($urandom_range(0, 7));
          po[k] = 7'($urandom_range(0, 127));
        end
      end
      if (!m_walking && !recover) retire = 3'($urandom_range(0, (sz > 4) ? 4 : sz));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
